mw_lmc1992: RTL and testbench

- Microwire receiver: the responder end of the STE sound-control microwire link driven by the shifter's DMA sound block.
- Emulates the LMC1992 volume/tone controller. Deserialises 11-bit commands, decodes address, function and data fields, and holds the control registers.
- Applies master and per-channel volume to the 8-bit DMA audio stream before it reaches the audio mixer.
- Sits between the shifter's audio outputs and the board audio path, all in the clk32 domain.

---
 rtl/mw_lmc1992.sv | 207 ++++++++++++++++++++
 tb/tb_mw_lmc1992.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mw_lmc1992.sv
// LMC1992 microwire responder: deserialises 11-bit commands into the tone/volume
// registers and applies master x channel volume to the 8-bit DMA audio stream.
`timescale 1ns/1ps
module mw_lmc1992 #(
  parameter logic [1:0] DEV_ADDR    = 2'b10,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk32,
  input  logic       resb,
  input  logic       mw_clk,
  input  logic       mw_data,
  input  logic       mw_en_n,
  input  logic       sample_en,
  input  logic [7:0] audio_in_l,
  input  logic [7:0] audio_in_r,
  output logic [7:0] audio_out_l,
  output logic [7:0] audio_out_r,
  output logic       out_valid,
  output logic [5:0] master_vol,
  output logic [4:0] left_vol,
  output logic [4:0] right_vol,
  output logic [3:0] bass,
  output logic [3:0] treble,
  output logic [1:0] mix,
  output logic       cmd_strobe
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync, en_sync;
  logic                   clk_d, en_d;
  logic                   clk_s, data_s, en_s;
  logic                   clk_rise, en_fall, en_rise;

  // NOTE: every flop is written with <= so all registers see pre-edge values,
  // making each always_ff independent of statement order.
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      clk_sync  <= '0;
      data_sync <= '0;
      en_sync   <= '1;
      clk_d     <= 1'b0;
      en_d      <= 1'b1;
    end else begin
      clk_sync[0]  <= mw_clk;
      data_sync[0] <= mw_data;
      en_sync[0]   <= mw_en_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync[i]  <= clk_sync[i-1];
        data_sync[i] <= data_sync[i-1];
        en_sync[i]   <= en_sync[i-1];
      end
      clk_d <= clk_s;
      en_d  <= en_s;
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];
  assign en_s     = en_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_d;
  assign en_fall  = ~en_s & en_d;
  assign en_rise  = en_s & ~en_d;

  logic [0:0]  state;
  logic [10:0] sr;
  logic [4:0]  bit_cnt;

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      state   <= ST_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en_fall) begin
            state   <= ST_SHIFT;
            sr      <= '0;
            bit_cnt <= '0;
          end
        end
        default: begin
          if (en_rise) begin
            state <= ST_IDLE;
          end else if (clk_rise) begin
            // Only the newest 11 bits survive, so over-long frames keep their tail.
            sr      <= {sr[9:0], data_s};
            bit_cnt <= (bit_cnt == 5'd31) ? bit_cnt : bit_cnt + 5'd1;
          end
        end
      endcase
    end
  end

  logic [2:0] func;
  logic [5:0] data;
  logic       cmd_ok;
  logic       strobe_pend;

  assign func   = sr[8:6];
  assign data   = sr[5:0];
  assign cmd_ok = (state == ST_SHIFT) && en_rise && (bit_cnt >= 5'd11) && (sr[10:9] == DEV_ADDR);

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      master_vol  <= 6'd40;
      left_vol    <= 5'd20;
      right_vol   <= 5'd20;
      bass        <= 4'd6;
      treble      <= 4'd6;
      mix         <= 2'b01;
      strobe_pend <= 1'b0;
      cmd_strobe  <= 1'b0;
    end else begin
      strobe_pend <= cmd_ok && (func <= 3'd5);
      cmd_strobe  <= strobe_pend;
      if (cmd_ok) begin
        case (func)
          3'd0: mix        <= data[1:0];
          3'd1: bass       <= (data[3:0] > 4'd12) ? 4'd12 : data[3:0];
          3'd2: treble     <= (data[3:0] > 4'd12) ? 4'd12 : data[3:0];
          3'd3: master_vol <= (data > 6'd40) ? 6'd40 : data;
          3'd4: right_vol  <= (data[4:0] > 5'd20) ? 5'd20 : data[4:0];
          3'd5: left_vol   <= (data[4:0] > 5'd20) ? 5'd20 : data[4:0];
          default: ;
        endcase
      end
    end
  end

  // round(256 * 10^(-k/10)); 2 dB per step, muted from step 25 onwards.
  function automatic logic [8:0] gain_lut(input logic [6:0] k);
    case (k)
      7'd0:  gain_lut = 9'd256;
      7'd1:  gain_lut = 9'd203;
      7'd2:  gain_lut = 9'd162;
      7'd3:  gain_lut = 9'd128;
      7'd4:  gain_lut = 9'd102;
      7'd5:  gain_lut = 9'd81;
      7'd6:  gain_lut = 9'd64;
      7'd7:  gain_lut = 9'd51;
      7'd8:  gain_lut = 9'd41;
      7'd9:  gain_lut = 9'd32;
      7'd10: gain_lut = 9'd26;
      7'd11: gain_lut = 9'd20;
      7'd12: gain_lut = 9'd16;
      7'd13: gain_lut = 9'd13;
      7'd14: gain_lut = 9'd10;
      7'd15: gain_lut = 9'd8;
      7'd16: gain_lut = 9'd6;
      7'd17: gain_lut = 9'd5;
      7'd18: gain_lut = 9'd4;
      7'd19: gain_lut = 9'd3;
      7'd20: gain_lut = 9'd3;
      7'd21: gain_lut = 9'd2;
      7'd22: gain_lut = 9'd2;
      7'd23: gain_lut = 9'd1;
      7'd24: gain_lut = 9'd1;
      default: gain_lut = 9'd0;
    endcase
  endfunction

  // Result is always within -128..127, so the low byte of the shift is exact;
  // flipping the MSB re-applies the +128 offset.
  function automatic logic [7:0] apply_gain(input logic signed [7:0] s, input logic [8:0] g);
    logic signed [17:0] p;
    p = 18'(s) * 18'(signed'({1'b0, g}));
    return 8'(p >>> 8) ^ 8'h80;
  endfunction

  logic [6:0]        k_l, k_r;
  logic signed [7:0] s_l, s_r;
  logic [8:0]        g_l, g_r;
  logic              v1;

  assign k_l = 7'd60 - {1'b0, master_vol} - {2'b0, left_vol};
  assign k_r = 7'd60 - {1'b0, master_vol} - {2'b0, right_vol};

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      s_l         <= '0;
      s_r         <= '0;
      g_l         <= '0;
      g_r         <= '0;
      v1          <= 1'b0;
      audio_out_l <= 8'd128;
      audio_out_r <= 8'd128;
      out_valid   <= 1'b0;
    end else begin
      v1        <= sample_en;
      out_valid <= v1;
      if (sample_en) begin
        s_l <= $signed(audio_in_l ^ 8'h80);
        s_r <= $signed(audio_in_r ^ 8'h80);
        g_l <= gain_lut(k_l);
        g_r <= gain_lut(k_r);
      end
      if (v1) begin
        audio_out_l <= apply_gain(s_l, g_l);
        audio_out_r <= apply_gain(s_r, g_r);
      end
    end
  end

endmodule

// File: tb/tb_mw_lmc1992.sv
// Randomised bench for mw_lmc1992 against a behavioural model of the command
// decoder and the dB-domain volume law.
`timescale 1ns/1ps
module tb_mw_lmc1992;

  logic       clk32 = 1'b0;
  logic       resb = 1'b0;
  logic       mw_clk = 1'b0, mw_data = 1'b0, mw_en_n = 1'b1;
  logic       sample_en = 1'b0;
  logic [7:0] audio_in_l = 8'd128, audio_in_r = 8'd128;
  logic [7:0] audio_out_l, audio_out_r;
  logic       out_valid, cmd_strobe;
  logic [5:0] master_vol;
  logic [4:0] left_vol, right_vol;
  logic [3:0] bass, treble;
  logic [1:0] mix;

  mw_lmc1992 dut (
    .clk32(clk32), .resb(resb), .mw_clk(mw_clk), .mw_data(mw_data), .mw_en_n(mw_en_n),
    .sample_en(sample_en), .audio_in_l(audio_in_l), .audio_in_r(audio_in_r),
    .audio_out_l(audio_out_l), .audio_out_r(audio_out_r), .out_valid(out_valid),
    .master_vol(master_vol), .left_vol(left_vol), .right_vol(right_vol),
    .bass(bass), .treble(treble), .mix(mix), .cmd_strobe(cmd_strobe)
  );

  always #16 clk32 = ~clk32;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int strobe_long = 0;
  logic strobe_prev = 1'b0;

  typedef struct {logic [7:0] l; logic [7:0] r; int cyc;} obs_t;
  obs_t obs_q[$];

  always @(posedge clk32) cyc <= cyc + 1;

  always @(negedge clk32) begin
    if (out_valid) obs_q.push_back('{audio_out_l, audio_out_r, cyc});
    if (cmd_strobe) strobe_cnt <= strobe_cnt + 1;
    if (cmd_strobe && strobe_prev) strobe_long <= strobe_long + 1;
    strobe_prev <= cmd_strobe;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model of the controller registers.
  int m_master, m_left, m_right, m_bass, m_treble, m_mix;

  function automatic void model_reset();
    m_master = 40; m_left = 20; m_right = 20; m_bass = 6; m_treble = 6; m_mix = 1;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Returns the number of strobes the command should produce.
  function automatic int model_cmd(input logic [31:0] bits, input int n);
    logic [10:0] w;
    int d;
    if (n < 11) return 0;
    w = bits[10:0];
    if (w[10:9] != 2'b10) return 0;
    d = int'(w[5:0]);
    case (w[8:6])
      3'd0: m_mix    = d % 4;
      3'd1: m_bass   = min_i(d % 16, 12);
      3'd2: m_treble = min_i(d % 16, 12);
      3'd3: m_master = min_i(d, 40);
      3'd4: m_right  = min_i(d % 32, 20);
      3'd5: m_left   = min_i(d % 32, 20);
      default: return 0;
    endcase
    return 1;
  endfunction

  function automatic int gain(input int k);
    real v;
    if (k >= 25) return 0;
    v = 256.0 * $pow(10.0, -k / 10.0);
    return $rtoi(v + 0.5);
  endfunction

  function automatic logic [7:0] scale(input logic [7:0] x, input int g);
    int s;
    s = int'(x) - 128;
    return 8'(128 + ((s * g) >>> 8));
  endfunction

  function automatic logic [7:0] exp_l(input logic [7:0] x);
    return scale(x, gain((40 - m_master) + (20 - m_left)));
  endfunction

  function automatic logic [7:0] exp_r(input logic [7:0] x);
    return scale(x, gain((40 - m_master) + (20 - m_right)));
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk32);
      #1;
    end
  endtask

  task automatic mw_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mw_data = bits[i];
      tick(3);
      mw_clk = 1'b1;
      tick(3);
      mw_clk = 1'b0;
      tick(2);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_master"}, master_vol, m_master);
    check({tag, "_left"},   left_vol,   m_left);
    check({tag, "_right"},  right_vol,  m_right);
    check({tag, "_bass"},   bass,       m_bass);
    check({tag, "_treble"}, treble,     m_treble);
    check({tag, "_mix"},    mix,        m_mix);
  endtask

  task automatic do_cmd(input string tag, input logic [31:0] bits, input int n);
    int s0, exp_strobes;
    s0 = strobe_cnt;
    exp_strobes = model_cmd(bits, n);
    mw_en_n = 1'b0;
    tick(3);
    mw_bits(bits, n);
    tick(1);
    mw_en_n = 1'b1;
    tick(10);
    check({tag, "_strobe"}, strobe_cnt - s0, exp_strobes);
    check_regs(tag);
  endtask

  task automatic do_sample(input string tag, input logic [7:0] l, input logic [7:0] r,
                           output logic [7:0] got_l);
    logic [7:0] el, er;
    int dc;
    obs_t o;
    el = exp_l(l);
    er = exp_r(r);
    audio_in_l = l;
    audio_in_r = r;
    sample_en = 1'b1;
    dc = cyc;
    tick(1);
    sample_en = 1'b0;
    for (int t = 0; t < 8 && obs_q.size() == 0; t++) tick(1);
    got_l = 'x;
    if (obs_q.size() == 0) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      o = obs_q.pop_front();
      got_l = o.l;
      check({tag, "_l"}, o.l, el);
      check({tag, "_r"}, o.r, er);
      check({tag, "_latency"}, o.cyc - dc, 2);
    end
    tick(3);
    check({tag, "_extra_valid"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] g;
    logic [7:0] bl[8], br[8], old_l[8], new_l[8], er_b[8];
    int dcyc[8];
    int s0, first_new;
    bit sw;
    obs_t o;

    model_reset();
    tick(3);
    check_regs("reset");
    check("reset_out_l", audio_out_l, 128);
    check("reset_out_r", audio_out_r, 128);
    check("reset_valid", out_valid, 0);
    check("reset_strobe", cmd_strobe, 0);
    resb = 1'b1;
    tick(2);

    // Reset in the middle of a transfer wipes registers and the partial frame.
    do_cmd("left3", 32'(11'b10101000011), 11);
    mw_en_n = 1'b0;
    tick(3);
    mw_bits(32'b101100, 6);
    resb = 1'b0;
    mw_en_n = 1'b1;
    mw_clk = 1'b0;
    tick(2);
    model_reset();
    check_regs("rst_mid");
    check("rst_mid_out", audio_out_l, 128);
    resb = 1'b1;
    tick(4);
    obs_q.delete();
    do_sample("c0", 8'hC0, 8'h40, g);
    check("c0_literal", g, 8'hC0);

    do_cmd("master34", 32'(11'b10011100010), 11);
    do_sample("ff", 8'hFF, 8'h00, g);
    check("ff_literal", g, 159);

    do_cmd("right5",       32'(11'b10100000101), 11);
    do_cmd("right_clamp",  32'(11'b10100011111), 11);
    do_cmd("master_clamp", 32'(11'b10011111111), 11);
    do_cmd("mix2",         32'(11'b10000000010), 11);
    do_cmd("bass_clamp",   32'(11'b10001001111), 11);
    do_cmd("treble5",      32'(11'b10010000101), 11);

    do_cmd("short10",  32'(10'b1001100001), 10);
    do_cmd("addr01",   32'(11'b01011000101), 11);
    do_cmd("long13",   32'(13'b1110101001010), 13);
    do_cmd("zero",     32'd0, 0);
    do_cmd("func110",  32'(11'b10110000001), 11);

    do_cmd("master0", 32'(11'b10011000000), 11);
    do_sample("mute", 8'h00, 8'hFF, g);
    check("mute_literal", g, 128);
    do_cmd("master37", 32'(11'b10011100101), 11);
    do_cmd("left20",   32'(11'b10101010100), 11);
    do_sample("neg", 8'h00, 8'h80, g);
    check("neg_literal", g, 64);

    for (int it = 0; it < 40; it++) begin
      logic [31:0] bits;
      int n;
      bits = $urandom;
      bits[10:9] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      n = $urandom_range(9, 14);
      do_cmd("rnd_cmd", bits, n);
      for (int j = 0; j < 2; j++)
        do_sample("rnd_smp", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), g);
    end

    // Burst of 8 samples with a left-volume command completing mid-burst.
    do_cmd("b_master40", 32'(11'b10011101000), 11);
    do_cmd("b_left20",   32'(11'b10101010100), 11);
    mw_en_n = 1'b0;
    tick(3);
    mw_bits(32'(11'b10101001000), 11);
    tick(1);
    for (int i = 0; i < 8; i++) begin
      bl[i] = 8'($urandom_range(224, 255));
      br[i] = 8'($urandom_range(0, 255));
      old_l[i] = exp_l(bl[i]);
      er_b[i] = exp_r(br[i]);
    end
    s0 = strobe_cnt;
    void'(model_cmd(32'(11'b10101001000), 11));
    for (int i = 0; i < 8; i++) new_l[i] = exp_l(bl[i]);
    obs_q.delete();
    for (int i = 0; i < 8; i++) begin
      audio_in_l = bl[i];
      audio_in_r = br[i];
      sample_en = 1'b1;
      dcyc[i] = cyc;
      if (i == 2) mw_en_n = 1'b1;
      tick(1);
    end
    sample_en = 1'b0;
    tick(12);
    check("burst_count", obs_q.size(), 8);
    check("burst_strobe", strobe_cnt - s0, 1);
    check_regs("burst");
    if (obs_q.size() == 8) begin
      sw = 1'b0;
      first_new = 8;
      for (int i = 0; i < 8; i++) begin
        o = obs_q[i];
        if (!sw && o.l != old_l[i]) begin
          sw = 1'b1;
          first_new = i;
        end
        check("burst_l", o.l, sw ? new_l[i] : old_l[i]);
        check("burst_r", o.r, er_b[i]);
        check("burst_latency", o.cyc - dcyc[i], 2);
      end
      check("burst_switch_window", (first_new >= 3 && first_new <= 7), 1);
    end
    obs_q.delete();

    check("strobe_width", strobe_long, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
